// File: rtl/motor_pkg.sv
// Shared definitions for the stepper coil bus: phase patterns, decoder
// state encoding and the pattern-to-index lookup used by the decoder.
package motor_pkg;

    localparam logic [3:0] P0   = 4'b1100;
    localparam logic [3:0] P1   = 4'b0110;
    localparam logic [3:0] P2   = 4'b0011;
    localparam logic [3:0] P3   = 4'b1001;
    localparam logic [3:0] IDLE = 4'b0000;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_e;

    typedef enum logic {
        UNLOCKED = 1'b0,
        TRACKING = 1'b1
    } dec_state_e;

    typedef struct packed {
        logic   valid;
        phase_e idx;
    } phase_dec_t;

    // Maps a coil pattern onto its phase index; valid=0 for IDLE and illegal patterns.
    function automatic phase_dec_t phase_to_idx(input logic [3:0] coil);
        phase_dec_t r;
        r.valid = 1'b1;
        r.idx   = PH0;
        case (coil)
            P0:      r.idx = PH0;
            P1:      r.idx = PH1;
            P2:      r.idx = PH2;
            P3:      r.idx = PH3;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/stall_timer.sv
// Counts clk cycles since the last step; expired is high once the count
// has reached STALL_CYCLES-1. The count saturates there.
module stall_timer #(
    parameter int STALL_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic start,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(STALL_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    // Cycle counter: cleared by a step, advances while enabled, holds at LAST.
    always_ff @(posedge clk or negedge start) begin
        // NOTE: registered state uses non-blocking assignments so every flop
        // samples its inputs from before the edge, independent of block order.
        if (!start) begin
            count_q <= '0;
        end else if (restart) begin
            count_q <= '0;
        end else if (enable && (count_q != LAST)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/stepper_phase_decoder.sv
// Decodes the 4-bit stepper coil bus into step pulses, direction and a
// wrapping signed position, with sticky fault flags and a stall indication.
module stepper_phase_decoder
    import motor_pkg::*;
#(
    parameter int POS_W        = 16,
    parameter int STALL_CYCLES = 10_000_000
) (
    input  logic                    clk,
    input  logic                    start,
    input  logic [3:0]              coil_i,
    input  logic                    clear_pos,
    input  logic                    clear_faults,
    output logic                    step_pulse,
    output logic                    step_dir,
    output logic signed [POS_W-1:0] position,
    output logic [1:0]              phase_idx,
    output logic                    locked,
    output logic                    moving,
    output logic                    fault_illegal,
    output logic                    fault_skip
);

    dec_state_e       state_q, state_d;
    phase_e           phase_q, phase_d;
    logic [3:0]       coil_q;
    logic [POS_W-1:0] pos_q;
    phase_dec_t       dec;
    logic             changed;
    logic [1:0]       delta;
    logic             step_d;
    logic             fwd_d;
    logic             skip_set;
    logic             illegal_set;
    logic             leave_track;
    logic             stall_expired;

    assign dec     = phase_to_idx(coil_i);
    assign changed = (coil_i != coil_q);
    assign delta   = dec.idx - phase_q;

    // Next-state and per-edge event decode from the newly sampled coil pattern.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        phase_d     = phase_q;
        step_d      = 1'b0;
        fwd_d       = 1'b0;
        skip_set    = 1'b0;
        illegal_set = 1'b0;
        leave_track = 1'b0;
        case (state_q)
            UNLOCKED: begin
                if (changed) begin
                    if (dec.valid) begin
                        state_d = TRACKING;
                        phase_d = dec.idx;
                    end else if (coil_i != IDLE) begin
                        illegal_set = 1'b1;
                    end
                end
            end
            TRACKING: begin
                if (changed) begin
                    if (dec.valid) begin
                        phase_d = dec.idx;
                        case (delta)
                            2'd1: begin
                                step_d = 1'b1;
                                fwd_d  = 1'b1;
                            end
                            2'd3:    step_d   = 1'b1;
                            2'd2:    skip_set = 1'b1;
                            default: ;
                        endcase
                    end else begin
                        state_d     = UNLOCKED;
                        leave_track = 1'b1;
                        illegal_set = (coil_i != IDLE);
                    end
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    // Decoder state register.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state_q <= UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    // Coil history, phase, step outputs, position, faults and moving flag.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            coil_q        <= IDLE;
            phase_q       <= PH0;
            step_pulse    <= 1'b0;
            step_dir      <= 1'b0;
            pos_q         <= '0;
            fault_illegal <= 1'b0;
            fault_skip    <= 1'b0;
            moving        <= 1'b0;
        end else begin
            coil_q     <= coil_i;
            phase_q    <= phase_d;
            step_pulse <= step_d;
            if (step_d) begin
                step_dir <= fwd_d;
            end
            // A clear coincident with a step wins; the pulse is still issued.
            if (clear_pos) begin
                pos_q <= '0;
            end else if (step_d) begin
                pos_q <= fwd_d ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
            end
            // New faults take priority over a same-cycle clear.
            fault_illegal <= illegal_set | (fault_illegal & ~clear_faults);
            fault_skip    <= skip_set    | (fault_skip    & ~clear_faults);
            if (step_d) begin
                moving <= 1'b1;
            end else if (leave_track || stall_expired) begin
                moving <= 1'b0;
            end
        end
    end

    stall_timer #(
        .STALL_CYCLES(STALL_CYCLES)
    ) u_stall_timer (
        .clk    (clk),
        .start  (start),
        .restart(step_d),
        .enable (moving),
        .expired(stall_expired)
    );

    assign position  = pos_q;
    assign phase_idx = phase_q;
    assign locked    = (state_q == TRACKING);

endmodule

// File: doc/stepper_phase_decoder.md
Name: stepper_phase_decoder

Overview:
- Decodes the 4-bit stepper coil pattern produced by the motor drive FSM back into step events, direction and a signed shaft position.
- Provides closed-loop visibility of the wheel drive for obstacle-avoidance logic and the seven-segment debug display.
- Sits on the clk domain, tapping the same coil bus that drives the motor board.
- Also flags illegal coil patterns, skipped phases and stalls.

Parameters:
POS_W, 16, width of signed position counter (two's complement, wraps)
STALL_CYCLES, 10_000_000, clk cycles without a step before moving deasserts (0.1 s at 100 MHz)

Ports:
clk  input  1  system clock
start  input  1  reset, asynchronous, active-low
coil_i  input  4  coil pattern, synchronous to clk
clear_pos  input  1  synchronous clear of position
clear_faults  input  1  synchronous clear of sticky faults
step_pulse  output  1  one-cycle pulse per decoded step
step_dir  output  1  1 = forward (right) sequence, 0 = reverse; holds last value
position  output  POS_W  signed step count
phase_idx  output  2  index of last valid phase
locked  output  1  decoder has a valid reference phase
moving  output  1  a step occurred within the last STALL_CYCLES cycles
fault_illegal  output  1  sticky, illegal coil pattern seen
fault_skip  output  1  sticky, two-phase jump seen

Behaviour:
- Reset (start=0, async): state UNLOCKED, coil_q=0000, all outputs 0, position=0.
- Phase table: P0=1100, P1=0110, P2=0011, P3=1001, IDLE=0000. Any other value is illegal.
- coil_i is registered into coil_q each clk. Decode acts when coil_i != coil_q. All outputs are registered and update on the same edge that samples the new pattern (1-cycle latency).
- UNLOCKED:
  - valid phase -> TRACKING; phase_idx=new; locked=1; no step counted.
  - IDLE -> stay UNLOCKED.
  - illegal -> fault_illegal=1, stay UNLOCKED.
- TRACKING, on change, with d = (new_idx - phase_idx) mod 4:
  - d=1: step_pulse=1, step_dir=1, position+1.
  - d=3: step_pulse=1, step_dir=0, position-1.
  - d=2: fault_skip=1, no count, phase_idx resyncs to new, stay TRACKING.
- TRACKING, non-phase inputs:
  - IDLE -> UNLOCKED, locked=0; phase_idx and position hold.
  - illegal -> fault_illegal=1, UNLOCKED, locked=0.
- Unchanged input: no action.
- Position arithmetic: POS_W-bit two's complement, wraps silently. 0x7FFF+1 = 0x8000; 0x8000-1 = 0x7FFF.
- Stall timer:
  - Reloads to 0 on every step_pulse.
  - Increments while moving=1; saturates.
  - moving=1 on the edge of any step_pulse.
  - moving=0 when the timer reaches STALL_CYCLES-1 with no step, or on leaving TRACKING.
- Simultaneous events:
  - clear_pos with a step: position=0, but step_pulse/step_dir are still issued.
  - clear_faults with a new fault: fault is set (set wins).
  - clear_pos in UNLOCKED: allowed.
- Reset asserted mid-step: all state is discarded. The first valid phase after reset only locks and does not count.

Decomposition:
- Shared package motor_pkg:
  - phase constants P0..P3 and IDLE (4-bit);
  - phase enum typedef;
  - decoder state typedef {UNLOCKED, TRACKING};
  - function phase_to_idx returning a valid flag plus 2-bit index.
- Sub-module stall_timer (clk, start, restart, enable, expired), parameterised by STALL_CYCLES.
- Remaining decode, counter and fault logic in the top module.

Test Plan:
- Reset, then coil 1100,0110,0011,1001,1100, each held 4 cycles -> locked=1 after first; 4 step_pulses, step_dir=1, position=4, no faults.
- From lock at 1001: 0011,0110,1100 -> 3 pulses, step_dir=0, position=-3 (0xFFFD).
- Locked at P0, apply 0011 -> fault_skip=1, no pulse, phase_idx=2; then 1001 counts +1. Then pulse clear_faults -> fault_skip=0.
- Apply 1111 while TRACKING -> fault_illegal=1, locked=0, next 0110 locks without counting.
- STALL_CYCLES=8: one step, then hold -> moving=1 for exactly 8 cycles then 0; next step reasserts moving.
- Preload position 0x7FFF via steps (POS_W=16), one forward step -> 0x8000. Then clear_pos coincident with a step -> position=0 and step_pulse=1. Then start=0 mid-sequence -> all outputs 0 immediately.
